// File: rtl/timer_pkg.sv
// Shared defaults and helpers for the two-digit cascade timer.
// Holds digit widths/moduli, count-direction encoding and load saturation.
package timer_pkg;

  localparam int unsigned LOW_W_DEF    = 4;
  localparam int unsigned LOW_MOD_DEF  = 10;
  localparam int unsigned HIGH_W_DEF   = 3;
  localparam int unsigned HIGH_MOD_DEF = 6;

  localparam logic DIR_UP   = 1'b0;
  localparam logic DIR_DOWN = 1'b1;

  // Clamp a load value into the digit's legal range 0..mod-1.
  function automatic int unsigned sat_to_mod(input int unsigned val, input int unsigned mod);
    return (val >= mod) ? (mod - 1) : val;
  endfunction

endpackage

// File: rtl/mod_counter.sv
// Single modulo-MOD up/down digit with clear, saturating load and a
// combinational terminal-count flag that marks a wrap on the coming edge.
module mod_counter
  import timer_pkg::*;
#(
  parameter int unsigned W   = 4,
  parameter int unsigned MOD = 10
) (
  input  logic         i_clk,
  input  logic         i_rstn,
  input  logic         i_step,
  input  logic         i_down,
  input  logic         i_clr,
  input  logic         i_load,
  input  logic [W-1:0] i_load_val,
  output logic [W-1:0] o_value,
  output logic         o_tc
);

  localparam logic [W-1:0] MaxVal = W'(MOD - 1);

  logic [W-1:0] r_value;
  logic [W-1:0] w_next;
  logic [W-1:0] w_load_sat;
  logic         w_at_edge;

  assign w_load_sat = W'(sat_to_mod(32'(i_load_val), MOD));
  assign w_at_edge  = (i_down == DIR_DOWN) ? (r_value == '0) : (r_value == MaxVal);

  // Only a genuine counting step may flag a wrap; clr/load override it.
  assign o_tc = i_step & ~i_clr & ~i_load & w_at_edge;

  always_comb begin
    w_next = r_value;
    if (i_clr) begin
      w_next = '0;
    end else if (i_load) begin
      w_next = w_load_sat;
    end else if (i_step) begin
      if (i_down == DIR_DOWN) begin
        w_next = w_at_edge ? MaxVal : (r_value - W'(1));
      end else begin
        w_next = w_at_edge ? '0 : (r_value + W'(1));
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rstn) begin
      r_value <= '0;
    end else begin
      r_value <= w_next;
    end
  end

  assign o_value = r_value;

endmodule

// File: rtl/cascade_timer.sv
// Two-digit cascaded modulo timer: a fast low digit whose wrap steps a slow
// high digit, with registered wrap pulses for each level.
module cascade_timer
  import timer_pkg::*;
#(
  parameter int unsigned LOW_W    = LOW_W_DEF,
  parameter int unsigned LOW_MOD  = LOW_MOD_DEF,
  parameter int unsigned HIGH_W   = HIGH_W_DEF,
  parameter int unsigned HIGH_MOD = HIGH_MOD_DEF
) (
  input  logic              i_clk,
  input  logic              i_rstn,
  input  logic              i_en,
  input  logic              i_clr,
  input  logic              i_load,
  input  logic [LOW_W-1:0]  i_load_low,
  input  logic [HIGH_W-1:0] i_load_high,
  input  logic              i_down,
  output logic [LOW_W-1:0]  o_nums,
  output logic [HIGH_W-1:0] o_cout,
  output logic              o_low_tc,
  output logic              o_wrap
);

  logic w_low_tc;
  logic w_high_tc;
  logic w_high_step;
  logic r_low_tc;
  logic r_wrap;

  assign w_high_step = w_low_tc & i_en;

  mod_counter #(
    .W   (LOW_W),
    .MOD (LOW_MOD)
  ) u_low (
    .i_clk      (i_clk),
    .i_rstn     (i_rstn),
    .i_step     (i_en),
    .i_down     (i_down),
    .i_clr      (i_clr),
    .i_load     (i_load),
    .i_load_val (i_load_low),
    .o_value    (o_nums),
    .o_tc       (w_low_tc)
  );

  mod_counter #(
    .W   (HIGH_W),
    .MOD (HIGH_MOD)
  ) u_high (
    .i_clk      (i_clk),
    .i_rstn     (i_rstn),
    .i_step     (w_high_step),
    .i_down     (i_down),
    .i_clr      (i_clr),
    .i_load     (i_load),
    .i_load_val (i_load_high),
    .o_value    (o_cout),
    .o_tc       (w_high_tc)
  );

  always_ff @(posedge i_clk) begin
    if (!i_rstn) begin
      r_low_tc <= 1'b0;
      r_wrap   <= 1'b0;
    end else begin
      r_low_tc <= w_low_tc;
      r_wrap   <= w_low_tc & w_high_tc;
    end
  end

  assign o_low_tc = r_low_tc;
  assign o_wrap   = r_wrap;

  a_nums_range : assert property (@(posedge i_clk) 32'(o_nums) <= LOW_MOD - 1);
  a_cout_range : assert property (@(posedge i_clk) 32'(o_cout) <= HIGH_MOD - 1);

  // The high digit may move only on a low-digit wrap, clr, load or reset.
  a_cout_stable : assert property (@(posedge i_clk)
    (i_rstn && !i_clr && !i_load && !w_low_tc) |=> $stable(o_cout));

endmodule

// File: tb/tb_cascade_timer.sv
// Directed self-checking bench for cascade_timer: a vector table plus
// hand-written multi-cycle sequences and a parameter-sweep instance.
module tb_cascade_timer;

  logic       clk = 1'b0;
  always #5 clk = ~clk;

  logic       rstn, en, clr, load, down;
  logic [3:0] load_low;
  logic [2:0] load_high;
  logic [3:0] nums;
  logic [2:0] cout;
  logic       low_tc, wrap;

  logic       s_rstn, s_en, s_clr, s_load, s_down;
  logic [3:0] s_load_low;
  logic [0:0] s_load_high;
  logic [3:0] s_nums;
  logic [0:0] s_cout;
  logic       s_low_tc, s_wrap;

  int n_vec = 0;
  int n_err = 0;

  cascade_timer dut (
    .i_clk       (clk),
    .i_rstn      (rstn),
    .i_en        (en),
    .i_clr       (clr),
    .i_load      (load),
    .i_load_low  (load_low),
    .i_load_high (load_high),
    .i_down      (down),
    .o_nums      (nums),
    .o_cout      (cout),
    .o_low_tc    (low_tc),
    .o_wrap      (wrap)
  );

  cascade_timer #(
    .LOW_W    (4),
    .LOW_MOD  (16),
    .HIGH_W   (1),
    .HIGH_MOD (2)
  ) dut_sweep (
    .i_clk       (clk),
    .i_rstn      (s_rstn),
    .i_en        (s_en),
    .i_clr       (s_clr),
    .i_load      (s_load),
    .i_load_low  (s_load_low),
    .i_load_high (s_load_high),
    .i_down      (s_down),
    .o_nums      (s_nums),
    .o_cout      (s_cout),
    .o_low_tc    (s_low_tc),
    .o_wrap      (s_wrap)
  );

  typedef struct {
    string      name;
    logic       rstn, en, clr, load, down;
    logic [3:0] ll;
    logic [2:0] lh;
    int         e_nums, e_cout, e_tc, e_wrap;
  } vec_t;

  vec_t vecs[23];

  task automatic check(input string name, input int an, input int ac, input int at,
                       input int aw, input int en_, input int ec, input int et, input int ew);
    n_vec++;
    if (an != en_ || ac != ec || at != et || aw != ew) begin
      n_err++;
      $display("FAIL %s: got nums=%0d cout=%0d low_tc=%0d wrap=%0d, expected %0d %0d %0d %0d",
               name, an, ac, at, aw, en_, ec, et, ew);
    end
  endtask

  task automatic check_int(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic drive(input logic r, input logic e, input logic c, input logic l,
                       input logic d, input logic [3:0] ll, input logic [2:0] lh);
    rstn = r; en = e; clr = c; load = l; down = d; load_low = ll; load_high = lh;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_main(input string name, input int n, input int c, input int t,
                            input int w);
    check(name, int'(nums), int'(cout), int'(low_tc), int'(wrap), n, c, t, w);
  endtask

  initial begin
    int wraps, tcs, tot;

    vecs[0]  = '{"rst",          0, 0, 0, 0, 0, 4'd0,  3'd0, 0, 0, 0, 0};
    vecs[1]  = '{"rst_ignores",  0, 1, 0, 1, 0, 4'd5,  3'd3, 0, 0, 0, 0};
    vecs[2]  = '{"first_up",     1, 1, 0, 0, 0, 4'd0,  3'd0, 1, 0, 0, 0};
    vecs[3]  = '{"load_9_0",     1, 1, 0, 1, 0, 4'd9,  3'd0, 9, 0, 0, 0};
    vecs[4]  = '{"up_carry",     1, 1, 0, 0, 0, 4'd0,  3'd0, 0, 1, 1, 0};
    vecs[5]  = '{"hold",         1, 0, 0, 0, 0, 4'd0,  3'd0, 0, 1, 0, 0};
    vecs[6]  = '{"down_borrow",  1, 1, 0, 0, 1, 4'd0,  3'd0, 9, 0, 1, 0};
    vecs[7]  = '{"down_8",       1, 1, 0, 0, 1, 4'd0,  3'd0, 8, 0, 0, 0};
    vecs[8]  = '{"load_sat",     1, 1, 0, 1, 0, 4'd12, 3'd7, 9, 5, 0, 0};
    vecs[9]  = '{"up_full_wrap", 1, 1, 0, 0, 0, 4'd0,  3'd0, 0, 0, 1, 1};
    vecs[10] = '{"up_after",     1, 1, 0, 0, 0, 4'd0,  3'd0, 1, 0, 0, 0};
    vecs[11] = '{"toggle_down",  1, 1, 0, 0, 1, 4'd0,  3'd0, 0, 0, 0, 0};
    vecs[12] = '{"dn_full_wrap", 1, 1, 0, 0, 1, 4'd0,  3'd0, 9, 5, 1, 1};
    vecs[13] = '{"clr_and_load", 1, 1, 1, 1, 0, 4'd3,  3'd2, 0, 0, 0, 0};
    vecs[14] = '{"load_over_en", 1, 1, 0, 1, 1, 4'd0,  3'd3, 0, 3, 0, 0};
    vecs[15] = '{"down_borrow2", 1, 1, 0, 0, 1, 4'd0,  3'd0, 9, 2, 1, 0};
    vecs[16] = '{"clr_over_en",  1, 1, 1, 0, 1, 4'd0,  3'd0, 0, 0, 0, 0};
    vecs[17] = '{"load_9_5",     1, 0, 0, 1, 0, 4'd9,  3'd5, 9, 5, 0, 0};
    vecs[18] = '{"rst_mid",      0, 1, 0, 0, 0, 4'd0,  3'd0, 0, 0, 0, 0};
    vecs[19] = '{"post_rst_up",  1, 1, 0, 0, 0, 4'd0,  3'd0, 1, 0, 0, 0};
    vecs[20] = '{"rst_again",    0, 0, 0, 0, 0, 4'd0,  3'd0, 0, 0, 0, 0};
    vecs[21] = '{"post_rst_dn",  1, 1, 0, 0, 1, 4'd0,  3'd0, 9, 5, 1, 1};
    vecs[22] = '{"hold_after",   1, 0, 0, 0, 1, 4'd0,  3'd0, 9, 5, 0, 0};

    drive(0, 0, 0, 0, 0, 4'd0, 3'd0);
    s_rstn = 0; s_en = 0; s_clr = 0; s_load = 0; s_down = 0;
    s_load_low = 4'd0; s_load_high = 1'b0;

    foreach (vecs[i]) begin
      drive(vecs[i].rstn, vecs[i].en, vecs[i].clr, vecs[i].load, vecs[i].down,
            vecs[i].ll, vecs[i].lh);
      tick();
      check_main(vecs[i].name, vecs[i].e_nums, vecs[i].e_cout, vecs[i].e_tc, vecs[i].e_wrap);
    end

    // 60 up cycles from reset: one full revolution of both digits.
    drive(0, 0, 0, 0, 0, 4'd0, 3'd0);
    tick();
    check_main("up60_rst", 0, 0, 0, 0);
    drive(1, 1, 0, 0, 0, 4'd0, 3'd0);
    wraps = 0;
    for (int k = 1; k <= 60; k++) begin
      tick();
      wraps += int'(wrap);
      check_main($sformatf("up60_k%0d", k), k % 10, (k / 10) % 6,
                 int'(k % 10 == 0), int'(k % 60 == 0));
    end
    check_int("up60_wrap_count", wraps, 1);

    // Load 27 then count down through the 20 -> 19 borrow.
    drive(1, 1, 0, 1, 1, 4'd7, 3'd2);
    tick();
    check_main("dn8_load", 7, 2, 0, 0);
    drive(1, 1, 0, 0, 1, 4'd0, 3'd0);
    tcs = 0;
    for (int k = 1; k <= 8; k++) begin
      tick();
      tcs += int'(low_tc);
      tot = 27 - k;
      check_main($sformatf("dn8_k%0d", k), tot % 10, tot / 10, int'(k == 8), 0);
    end
    check_int("dn8_tc_count", tcs, 1);

    // Count, freeze with en low, then clr+load together while counting.
    drive(1, 1, 1, 0, 0, 4'd0, 3'd0);
    tick();
    drive(1, 1, 0, 0, 0, 4'd0, 3'd0);
    for (int k = 1; k <= 3; k++) begin
      tick();
      check_main($sformatf("frz_up%0d", k), k, 0, 0, 0);
    end
    drive(1, 0, 0, 0, 0, 4'd0, 3'd0);
    for (int k = 1; k <= 5; k++) begin
      tick();
      check_main($sformatf("frz_hold%0d", k), 3, 0, 0, 0);
    end
    drive(1, 1, 1, 1, 0, 4'd9, 3'd4);
    tick();
    check_main("frz_clr_load", 0, 0, 0, 0);

    // Sweep instance: 16 x 2 digits, full revolution up then down.
    s_rstn = 0;
    tick();
    check("sw_rst", int'(s_nums), int'(s_cout), int'(s_low_tc), int'(s_wrap), 0, 0, 0, 0);
    s_rstn = 1; s_en = 1; s_down = 0;
    for (int k = 1; k <= 32; k++) begin
      tick();
      check($sformatf("sw_up_k%0d", k), int'(s_nums), int'(s_cout), int'(s_low_tc),
            int'(s_wrap), k % 16, (k / 16) % 2, int'(k % 16 == 0), int'(k % 32 == 0));
    end
    s_down = 1;
    for (int k = 1; k <= 32; k++) begin
      tick();
      tot = (32 - (k % 32)) % 32;
      check($sformatf("sw_dn_k%0d", k), int'(s_nums), int'(s_cout), int'(s_low_tc),
            int'(s_wrap), tot % 16, tot / 16, int'((k - 1) % 16 == 0),
            int'((k - 1) % 32 == 0));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
